phase_gen: RTL and testbench
============================

PHASE_GEN -- requirements
Module: phase_gen

Interface
REQ-001 Parameter NUM_LANES, default 5: samples per clock (500 MS/s at 100 MHz).
REQ-002 Parameter PHASE_W, default 14: phase word width; full turn = 2^14.
REQ-003 Parameter PHASE_STEPS, default 50: phase grid points per turn (10 MHz resolution at 500 MS/s).
REQ-004 clk100  in  1  100 MHz system clock; one clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start_collect  in  1  level; sampled only in IDLE; starts a run.
REQ-007 demod_freq  in  4  demod frequency in 10 MHz units (0 = DC, 15 = 150 MHz).
REQ-008 sample_length  in  11  run length in clk100 cycles (2000 = 20 us).
REQ-009 phase_vals  out  NUM_LANES*PHASE_W  packed lanes; lane k at bits [14k+13:14k]; lane 0 is the earliest sample; feeds the multiplier phase_vals input.
REQ-010 phase_valid  out  1  phase_vals holds a valid sample group.
REQ-011 busy  out  1  high from the latch cycle through the done cycle.
REQ-012 done  out  1  one-cycle pulse at end of run.

Function
REQ-013 The state machine SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-014 IDLE -> RUN on an edge with start_collect=1: latch demod_freq to f_q and sample_length to len_q; clear base index and cycle counter.
REQ-015 Inputs changing during RUN/DRAIN/DONE SHALL have no effect; start_collect outside IDLE is ignored.
REQ-016 Lane index: idx_k = (base + k*f_q) mod PHASE_STEPS, computed with compare-subtract only (no divider).
REQ-017 Base advance: base <= (base + NUM_LANES*f_q) mod PHASE_STEPS once per RUN cycle.
REQ-018 Phase lookup: phase = round(idx*2^PHASE_W/PHASE_STEPS), ties rounded up; table of 50 entries, 0..16056.
REQ-019 Pipeline: index stage registered, then LUT stage registered; the first phase_valid is high 2 cycles after the start-latch edge.
REQ-020 phase_valid SHALL be high for exactly len_q consecutive cycles, with base starting at 0 on the first group.
REQ-021 RUN -> DRAIN after len_q index groups are issued; DRAIN lasts until the pipeline empties; DRAIN -> DONE; DONE -> IDLE after one cycle.
REQ-022 done SHALL be high in the cycle immediately after the last phase_valid cycle.
REQ-023 sample_length=0: no phase_valid; done pulses 2 cycles after the latch edge.
REQ-024 f_q=0: every lane outputs 0 for the whole run.
REQ-025 phase_vals SHALL hold its last value when phase_valid=0; consumers qualify it with phase_valid.
REQ-026 start_collect held high through DONE: a new run latches on the first IDLE edge, 1 cycle after DONE.

Reset
REQ-027 On a reset edge the block SHALL go to IDLE and clear phase_vals, phase_valid, busy, done, base, counters and pipeline registers, including mid-run.
REQ-028 Reset SHALL win over a simultaneous start_collect.
REQ-029 No done pulse SHALL be generated for a run aborted by reset.

Structure
REQ-030 Package qubit_pkg SHALL hold NUM_LANES, PHASE_W, PHASE_STEPS, the state enum, the packed phase-lanes typedef and the LUT init function.
REQ-031 Sub-module phase_lut SHALL provide a registered 6-bit index to 14-bit phase lookup; phase_gen SHALL instantiate one per lane.
REQ-032 Total RTL SHALL be 120-400 lines; no multipliers (k*f_q is built from constant shifts and adds).

Verification
REQ-033 f=5, len=4, start pulse: valid 4 cycles; lanes alternate {0,1638,3277,4915,6554} and {8192,9830,11469,13107,14746}; done 1 cycle after the last valid.
REQ-034 f=0, len=3: three valid groups, all lanes 0; done pulse.
REQ-035 f=15, len=2000: 2000 valid cycles; first group {0,4915,9830,14746,3277}; unwrapped phase slope exactly 15 grid steps per sample throughout.
REQ-036 len=0: phase_valid never high; done exactly 2 cycles after the latch edge; busy back low next cycle.
REQ-037 Reset asserted on valid cycle 10 of a len=100 run: next edge all outputs 0, IDLE, no done; a fresh start then gives first group base 0.
REQ-038 demod_freq changed and start re-pulsed mid-run: outputs unaffected until done; start_collect held high gives back-to-back runs one IDLE cycle apart.

Source files
------------

// File: rtl/qubit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qubit_pkg
// Description : Shared constants, FSM state encodings, lane typedef and the
//               phase lookup-table entry function for the demod phase path.
// Revision    : 1.0 - initial release
// ============================================================================
package qubit_pkg;

    // Samples produced per clk100 cycle (500 MS/s at 100 MHz)
    localparam int NUM_LANES   = 5;
    // Phase word width; one full turn is 2**PHASE_W
    localparam int PHASE_W     = 14;
    // Phase grid points per turn (10 MHz resolution at 500 MS/s)
    localparam int PHASE_STEPS = 50;

    // Run-control state machine encodings
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    // Packed phase lanes; lane 0 is the earliest sample in the group
    typedef logic [NUM_LANES*PHASE_W-1:0] phase_lanes_t;

    // Table entry: round(idx * 2**w / steps) with ties rounded up,
    // evaluated at elaboration time to build the constant ROM.
    function automatic int phase_entry(input int idx, input int steps, input int w);
        return (idx * (2 ** w) * 2 + steps) / (2 * steps);
    endfunction

endpackage
`default_nettype wire

// File: rtl/phase_lut.sv
`default_nettype none
// ============================================================================
// Module      : phase_lut
// Description : Registered grid-index to phase-word lookup. Holds its last
//               output whenever the enable is low.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_lut #(
    parameter int PHASE_W     = qubit_pkg::PHASE_W,
    parameter int PHASE_STEPS = qubit_pkg::PHASE_STEPS,
    parameter int IDX_W       = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_en,
    input  logic [IDX_W-1:0]   i_idx,
    output logic [PHASE_W-1:0] o_phase
);
    import qubit_pkg::*;

    logic [PHASE_W-1:0] w_rom [2**IDX_W];
    logic [PHASE_W-1:0] r_phase;

    // Constant ROM; indices past the grid are unreachable and read as zero
    for (genvar i = 0; i < 2**IDX_W; i++) begin : g_rom
        if (i < PHASE_STEPS) begin : g_entry
            assign w_rom[i] = PHASE_W'(phase_entry(i, PHASE_STEPS, PHASE_W));
        end else begin : g_pad
            assign w_rom[i] = '0;
        end
    end

    // Registered lookup, updated only for valid index groups
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= '0;
        end else if (i_en) begin
            r_phase <= w_rom[i_idx];
        end
    end

    assign o_phase = r_phase;

endmodule
`default_nettype wire

// File: rtl/phase_gen.sv
`default_nettype none
// ============================================================================
// Module      : phase_gen
// Description : Generates NUM_LANES demodulation phase words per clock for a
//               run of sample_length cycles. Index stage and LUT stage are
//               both registered; done pulses the cycle after the last valid.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_gen #(
    parameter int NUM_LANES   = qubit_pkg::NUM_LANES,
    parameter int PHASE_W     = qubit_pkg::PHASE_W,
    parameter int PHASE_STEPS = qubit_pkg::PHASE_STEPS
) (
    input  logic                         clk100,
    input  logic                         reset,
    input  logic                         start_collect,
    input  logic [3:0]                   demod_freq,
    input  logic [10:0]                  sample_length,
    output logic [NUM_LANES*PHASE_W-1:0] phase_vals,
    output logic                         phase_valid,
    output logic                         busy,
    output logic                         done
);
    import qubit_pkg::*;

    localparam int c_IDX_W = $clog2(PHASE_STEPS);
    // One spare bit holds index + frequency before the wrap subtract
    localparam int c_SUM_W = c_IDX_W + 1;

    logic [1:0]         r_state;
    logic [3:0]         r_f_q;
    logic [10:0]        r_len_q;
    logic [10:0]        r_cnt;
    logic [c_IDX_W-1:0] r_base;
    logic               r_busy;
    logic               r_done;
    logic               r_idx_valid;
    logic               r_phase_valid;
    logic [c_IDX_W-1:0] r_idx   [NUM_LANES];
    logic [c_IDX_W-1:0] w_chain [NUM_LANES+1];
    logic               w_issue;

    // An index group is issued on every RUN cycle until len_q groups are out
    assign w_issue = (r_state == c_ST_RUN) && (r_cnt != r_len_q);

    // Lane k index is base + k*f mod STEPS, built as a chain of add-and-wrap
    // steps. Since f < STEPS each step needs at most one subtract; the extra
    // chain element is the next base (base + NUM_LANES*f).
    assign w_chain[0] = r_base;
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_chain
        logic [c_SUM_W-1:0] w_sum;
        assign w_sum = c_SUM_W'(w_chain[i]) + c_SUM_W'(r_f_q);
        assign w_chain[i+1] = (w_sum >= c_SUM_W'(PHASE_STEPS))
                            ? c_IDX_W'(w_sum - c_SUM_W'(PHASE_STEPS))
                            : c_IDX_W'(w_sum);
    end

    // Run control: latch parameters in IDLE, count groups in RUN, wait for
    // the index stage to empty in DRAIN, pulse done in DONE
    always_ff @(posedge clk100) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_f_q   <= '0;
            r_len_q <= '0;
            r_cnt   <= '0;
            r_base  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start_collect) begin
                        r_state <= c_ST_RUN;
                        r_f_q   <= demod_freq;
                        r_len_q <= sample_length;
                        r_cnt   <= '0;
                        r_base  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                c_ST_RUN: begin
                    if (w_issue) begin
                        r_base <= w_chain[NUM_LANES];
                        r_cnt  <= r_cnt + 11'd1;
                    end else begin
                        r_state <= c_ST_DRAIN;
                    end
                end
                c_ST_DRAIN: begin
                    if (!r_idx_valid) begin
                        r_state <= c_ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Index stage register and the valid flag travelling with each stage
    always_ff @(posedge clk100) begin
        if (reset) begin
            r_idx_valid   <= 1'b0;
            r_phase_valid <= 1'b0;
            for (int k = 0; k < NUM_LANES; k++) begin
                r_idx[k] <= '0;
            end
        end else begin
            r_idx_valid   <= w_issue;
            r_phase_valid <= r_idx_valid;
            if (w_issue) begin
                for (int k = 0; k < NUM_LANES; k++) begin
                    r_idx[k] <= w_chain[k];
                end
            end
        end
    end

    // One lookup per lane; outputs hold between valid groups
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        phase_lut #(
            .PHASE_W     (PHASE_W),
            .PHASE_STEPS (PHASE_STEPS),
            .IDX_W       (c_IDX_W)
        ) u_lut (
            .clk     (clk100),
            .rst     (reset),
            .i_en    (r_idx_valid),
            .i_idx   (r_idx[k]),
            .o_phase (phase_vals[k*PHASE_W +: PHASE_W])
        );
    end

    assign phase_valid = r_phase_valid;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_phase_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_phase_gen
// Description : Scoreboard bench for phase_gen. Stimulus pushes expected
//               phase groups and done cycles; a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_gen;
    localparam int NL = 5;
    localparam int PW = 14;
    localparam int PS = 50;
    localparam int GW = NL * PW;

    logic          clk100 = 1'b0;
    logic          reset = 1'b1;
    logic          start_collect = 1'b0;
    logic [3:0]    demod_freq = '0;
    logic [10:0]   sample_length = '0;
    logic [GW-1:0] phase_vals;
    logic          phase_valid;
    logic          busy;
    logic          done;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [GW-1:0] exp_q [$];
    int            done_q [$];
    logic [GW-1:0] mon_exp;
    int            mon_done;

    phase_gen dut (
        .clk100        (clk100),
        .reset         (reset),
        .start_collect (start_collect),
        .demod_freq    (demod_freq),
        .sample_length (sample_length),
        .phase_vals    (phase_vals),
        .phase_valid   (phase_valid),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk100 = ~clk100;

    // Edge counter; read on negedges where it is stable
    always @(posedge clk100) cyc <= cyc + 1;

    task automatic check(input string name, input logic [GW-1:0] act, input logic [GW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Group n of a run at frequency f, from the global sample index
    function automatic logic [GW-1:0] model_group(input int f, input int n);
        logic [GW-1:0] g;
        int idx;
        g = '0;
        for (int k = 0; k < NL; k++) begin
            idx = (n * NL * f + k * f) % PS;
            g[k*PW +: PW] = PW'((idx * (1 << PW) * 2 + PS) / (2 * PS));
        end
        return g;
    endfunction

    function automatic logic [GW-1:0] pack5(input int a, input int b, input int c, input int d, input int e);
        return {PW'(e), PW'(d), PW'(c), PW'(b), PW'(a)};
    endfunction

    task automatic push_model(input int f, input int len);
        for (int n = 0; n < len; n++) exp_q.push_back(model_group(f, n));
    endtask

    // Present a start pulse; records the latch edge and the expected done cycle
    task automatic launch(input int f, input int len, output int latch);
        @(negedge clk100);
        demod_freq    = 4'(f);
        sample_length = 11'(len);
        start_collect = 1'b1;
        @(posedge clk100);
        #1;
        latch = cyc;
        done_q.push_back(latch + len + 2);
        check("busy_after_latch", GW'(busy), GW'(1));
        @(negedge clk100);
        start_collect = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((done_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            @(posedge clk100);
            #2;
            n++;
        end
        tests++;
        if (done_q.size() != 0 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: %0d groups and %0d dones pending, expected 0 after %0d cycles",
                     exp_q.size(), done_q.size(), budget);
            exp_q.delete();
            done_q.delete();
        end
        repeat (2) @(posedge clk100);
        #1;
        check("busy_idle", GW'(busy), GW'(0));
    endtask

    // Scoreboard monitor
    always @(negedge clk100) begin
        if (phase_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid at cyc %0d: got %h expected no valid", cyc, phase_vals);
            end else begin
                mon_exp = exp_q.pop_front();
                check("phase_vals", phase_vals, mon_exp);
            end
        end
        if (done) begin
            if (done_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done at cyc %0d: got done=1 expected 0", cyc);
            end else begin
                mon_done = done_q.pop_front();
                check("done_cycle", GW'(cyc), GW'(mon_done));
                check("busy_at_done", GW'(busy), GW'(1));
                check("no_valid_at_done", GW'(phase_valid), GW'(0));
            end
        end
    end

    initial begin
        int latch;
        int nvalid;
        int guard;

        // Reset state
        repeat (3) @(posedge clk100);
        #1;
        check("rst_phase_vals", phase_vals, '0);
        check("rst_valid", GW'(phase_valid), GW'(0));
        check("rst_busy", GW'(busy), GW'(0));
        check("rst_done", GW'(done), GW'(0));
        @(negedge clk100);
        reset = 1'b0;

        // f=5, len=4: alternating groups
        exp_q.push_back(pack5(0, 1638, 3277, 4915, 6554));
        exp_q.push_back(pack5(8192, 9830, 11469, 13107, 14746));
        exp_q.push_back(pack5(0, 1638, 3277, 4915, 6554));
        exp_q.push_back(pack5(8192, 9830, 11469, 13107, 14746));
        launch(5, 4, latch);
        wait_drain(50);
        check("hold_after_run", phase_vals, pack5(8192, 9830, 11469, 13107, 14746));

        // f=0, len=3: all lanes zero
        repeat (3) exp_q.push_back('0);
        launch(0, 3, latch);
        wait_drain(50);

        // len=0: no valid, done 2 cycles after latch, busy low next cycle
        launch(9, 0, latch);
        while (cyc < latch + 3) @(posedge clk100);
        #1;
        check("len0_busy_low", GW'(busy), GW'(0));
        wait_drain(20);

        // f=15, len=2000: hand-computed first group, model slope thereafter
        exp_q.push_back(pack5(0, 4915, 9830, 14746, 3277));
        for (int n = 1; n < 2000; n++) exp_q.push_back(model_group(15, n));
        launch(15, 2000, latch);
        wait_drain(2100);

        // Reset on valid cycle 10 of a len=100 run
        push_model(3, 100);
        launch(3, 100, latch);
        nvalid = 0;
        guard  = 0;
        while (nvalid < 10 && guard < 200) begin
            @(negedge clk100);
            if (phase_valid) nvalid++;
            guard++;
        end
        reset = 1'b1;
        @(posedge clk100);
        #1;
        exp_q.delete();
        done_q.delete();
        check("abort_phase_vals", phase_vals, '0);
        check("abort_valid", GW'(phase_valid), GW'(0));
        check("abort_busy", GW'(busy), GW'(0));
        check("abort_done", GW'(done), GW'(0));
        @(negedge clk100);
        reset = 1'b0;
        repeat (6) @(posedge clk100);
        push_model(3, 5);
        launch(3, 5, latch);
        wait_drain(50);

        // Reset beats a simultaneous start
        @(negedge clk100);
        reset = 1'b1;
        start_collect = 1'b1;
        @(posedge clk100);
        #1;
        check("rst_vs_start_busy", GW'(busy), GW'(0));
        @(negedge clk100);
        reset = 1'b0;
        start_collect = 1'b0;
        repeat (3) @(posedge clk100);
        #1;
        check("rst_vs_start_idle", GW'(busy), GW'(0));

        // Inputs changed and start re-pulsed mid-run have no effect
        push_model(7, 20);
        launch(7, 20, latch);
        repeat (4) @(negedge clk100);
        demod_freq    = 4'd2;
        sample_length = 11'd5;
        start_collect = 1'b1;
        @(negedge clk100);
        start_collect = 1'b0;
        wait_drain(60);

        // start_collect held high: back-to-back runs one IDLE cycle apart
        push_model(4, 3);
        push_model(4, 3);
        @(negedge clk100);
        demod_freq    = 4'd4;
        sample_length = 11'd3;
        start_collect = 1'b1;
        @(posedge clk100);
        #1;
        latch = cyc;
        done_q.push_back(latch + 5);
        done_q.push_back(latch + 7 + 5);
        while (cyc < latch + 6) @(negedge clk100);
        check("held_idle_gap_busy", GW'(busy), GW'(0));
        @(posedge clk100);
        #1;
        check("held_relatch_busy", GW'(busy), GW'(1));
        @(negedge clk100);
        start_collect = 1'b0;
        wait_drain(50);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
